param_loader: RTL and testbench
===============================

PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_data  input  8  host byte stream (from UART receiver).
REQ-004 in_valid  input  1  in_data valid; a byte transfers when in_valid && in_ready.
REQ-005 in_ready  output  1  loader can accept a byte this cycle.
REQ-006 wr_addr  output  16  write address, shared by all parameter memories (port B).
REQ-007 wr_data  output  144  write data; 16-bit parameters packed at [16k+15:16k], k = 0..8.
REQ-008 we_conv_w  output  1  write strobe for the conv-weight memory: 144-bit word, 2576 entries.
REQ-009 we_conv_b  output  1  write strobe for the conv-bias memory: wr_data[15:0], 112 entries.
REQ-010 we_dense_w  output  1  write strobe for the dense-weight memory: wr_data[15:0], 33792 entries.
REQ-011 we_dense_b  output  1  write strobe for the dense-bias memory: wr_data[15:0], 192 entries.
REQ-012 busy  output  1  high from the first header byte until the frame ends.
REQ-013 done  output  1  one-cycle pulse when a frame completes successfully.
REQ-014 err  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-015 The loader SHALL accept frames in this byte order:
- TGT (1 byte): 0x01 conv_w, 0x02 conv_b, 0x03 dense_w, 0x04 dense_b.
- ADDR (2 bytes, MSB first).
- CNT (2 bytes, MSB first): number of memory words.
- Payload: CNT words. A conv_w word is 9 parameters (18 bytes); every other target's word is 1 parameter (2 bytes). Each parameter is sent LSB byte first.
REQ-016 The FSM SHALL have states IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CHECK, PAYLOAD, WRITE.
REQ-017 IDLE -> ADDR_HI on an accepted byte in 0x01..0x04; any other accepted byte SHALL pulse err and remain in IDLE.
REQ-018 ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO -> CHECK, advancing one state per accepted byte.
REQ-019 CHECK SHALL last one cycle with in_ready=0 and SHALL take exactly one of these branches:
- ADDR+CNT > target depth (17-bit compare): pulse err, go to IDLE.
- CNT==0: pulse done, go to IDLE.
- Otherwise: go to PAYLOAD.
REQ-020 PAYLOAD SHALL place accepted bytes into the word buffer at byte index b = 0..(2*P-1), where P = 9 for conv_w and P = 1 otherwise; byte b goes to bits [8b+7:8b].
REQ-021 After the last byte of a word, the FSM SHALL enter WRITE. In the following cycle exactly one we_* SHALL be high, with wr_addr = current address and wr_data = buffer.
- In WRITE, in_ready SHALL be 0.
REQ-022 After WRITE, the address SHALL increment and the remaining count SHALL decrement; the FSM returns to PAYLOAD, or to IDLE with a done pulse in the same cycle as the last write.
REQ-023 Buffer bits not written in a 1-parameter word SHALL be driven as 0.
REQ-024 in_ready SHALL be 1 in IDLE, ADDR_*, CNT_* and PAYLOAD, and 0 otherwise.
- in_ready SHALL depend only on registered state, with no combinational path from in_valid.
REQ-025 An idle in_valid gap of any length SHALL NOT change state.
- The loader has no timeout; the host is responsible for framing.
REQ-026 All we_* SHALL be 0 outside WRITE, and at most one SHALL be high in any cycle.

Reset
REQ-027 While rst=1 at a clock edge, the loader SHALL return to IDLE regardless of state, including mid-payload; the partial word SHALL be discarded.
REQ-028 Reset values: all we_*=0, busy=0, done=0, err=0, in_ready=0 during reset and 1 in the first cycle after, wr_addr=0, wr_data=0, counters=0.
REQ-029 Words written before a mid-frame reset SHALL remain written; no rollback.

Verification
REQ-030 Frame 02 00 05 00 02 34 12 CD AB -> we_conv_b at addr 5 with data 0x1234, then addr 6 with data 0xABCD; done pulses with the second write; busy then falls.
REQ-031 conv_w frame at addr 0x0010, CNT=1, parameters 1..9 -> a single we_conv_w with wr_data[16k+15:16k]=k+1; in_ready=0 during the write cycle.
REQ-032 Frame 04 00 BF 00 02 (191+2 > 192) -> err pulse in the CHECK cycle, no write; the next valid frame is accepted.
REQ-033 Byte 0x07 in IDLE -> err pulse and state stays IDLE; frame 03 00 00 00 00 -> done pulse and no write.
REQ-034 dense_w frame with random in_valid gaps (0-5 cycles) -> same writes as the gap-free run; addresses 33790..33791 are accepted at the boundary.
REQ-035 rst asserted after 7 of 18 conv_w payload bytes -> no write, IDLE, in_ready=1 after reset; a fresh frame then writes correctly.

Source files
------------

// File: rtl/param_loader.sv
// param_loader: receives parameter frames from a host byte stream (UART) and
// writes them into the four parameter memories through a shared write port.
//
// Frame: TGT(1) ADDR(2, MSB first) CNT(2, MSB first) then CNT words.
// A conv_w word carries 9 16-bit parameters (18 bytes); every other target's
// word carries 1 parameter (2 bytes). Parameters arrive LSB byte first.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/in_valid     host byte stream; a byte moves on in_valid && in_ready
//   in_ready             loader can take a byte (registered state only)
//   wr_addr/wr_data      shared write port; parameter k at wr_data[16k+15:16k]
//   we_conv_w/_conv_b    write strobes, one per memory, at most one high
//   we_dense_w/_dense_b
//   busy                 a frame is in progress
//   done/err             one-cycle frame completion / rejection pulses
module param_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [15:0]  wr_addr,
    output logic [143:0] wr_data,
    output logic         we_conv_w,
    output logic         we_conv_b,
    output logic         we_dense_w,
    output logic         we_dense_b,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [2:0]  TGT_CONV_W  = 3'd1;
    localparam logic [2:0]  TGT_CONV_B  = 3'd2;
    localparam logic [2:0]  TGT_DENSE_W = 3'd3;
    localparam logic [2:0]  TGT_DENSE_B = 3'd4;

    localparam logic [16:0] DEPTH_CONV_W  = 17'd2576;
    localparam logic [16:0] DEPTH_CONV_B  = 17'd112;
    localparam logic [16:0] DEPTH_DENSE_W = 17'd33792;
    localparam logic [16:0] DEPTH_DENSE_B = 17'd192;

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CHECK, PAYLOAD, WRITE
    } state_t;

    state_t         state, state_nx;
    logic [2:0]     tgt;
    logic [15:0]    addr;
    logic [15:0]    cnt;     // words still to be written
    logic [4:0]     bidx;    // byte position inside the current word
    logic [143:0]   wbuf;
    logic [16:0]    depth;
    logic [16:0]    end_addr;
    logic [4:0]     last_b;
    logic           accept;
    logic           tgt_ok;

    // Ready comes from state alone; rst gating keeps it low while reset is held.
    assign in_ready = !rst && (state inside {IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, PAYLOAD});
    assign accept   = in_valid && in_ready;
    assign tgt_ok   = (in_data >= 8'h01) && (in_data <= 8'h04);

    assign wr_addr  = addr;
    assign wr_data  = wbuf;

    always_comb begin
        case (tgt)
            TGT_CONV_W:  depth = DEPTH_CONV_W;
            TGT_CONV_B:  depth = DEPTH_CONV_B;
            TGT_DENSE_W: depth = DEPTH_DENSE_W;
            default:     depth = DEPTH_DENSE_B;
        endcase
    end

    // 17-bit sum so a range that runs past 0xFFFF is still rejected.
    assign end_addr = {1'b0, addr} + {1'b0, cnt};
    assign last_b   = (tgt == TGT_CONV_W) ? 5'd17 : 5'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        we_conv_w  = 1'b0;
        we_conv_b  = 1'b0;
        we_dense_w = 1'b0;
        we_dense_b = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (tgt_ok) state_nx = ADDR_HI;
                    else        err      = 1'b1;
                end
            end
            ADDR_HI: if (accept) state_nx = ADDR_LO;
            ADDR_LO: if (accept) state_nx = CNT_HI;
            CNT_HI:  if (accept) state_nx = CNT_LO;
            CNT_LO:  if (accept) state_nx = CHECK;
            CHECK: begin
                if (end_addr > depth) begin
                    err      = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == 16'd0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = PAYLOAD;
                end
            end
            PAYLOAD: if (accept && bidx == last_b) state_nx = WRITE;
            WRITE: begin
                case (tgt)
                    TGT_CONV_W:  we_conv_w  = 1'b1;
                    TGT_CONV_B:  we_conv_b  = 1'b1;
                    TGT_DENSE_W: we_dense_w = 1'b1;
                    default:     we_dense_b = 1'b1;
                endcase
                if (cnt == 16'd1) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = PAYLOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath. The buffer is cleared before every word so the unused upper
    // bits of a 1-parameter word always read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt  <= 3'd0;
            addr <= 16'd0;
            cnt  <= 16'd0;
            bidx <= 5'd0;
            wbuf <= '0;
        end else begin
            case (state)
                IDLE:    if (accept) tgt <= in_data[2:0];
                ADDR_HI: if (accept) addr[15:8] <= in_data;
                ADDR_LO: if (accept) addr[7:0]  <= in_data;
                CNT_HI:  if (accept) cnt[15:8]  <= in_data;
                CNT_LO:  if (accept) cnt[7:0]   <= in_data;
                CHECK: begin
                    bidx <= 5'd0;
                    wbuf <= '0;
                end
                PAYLOAD: begin
                    if (accept) begin
                        wbuf[{bidx, 3'b000} +: 8] <= in_data;
                        bidx <= (bidx == last_b) ? 5'd0 : bidx + 5'd1;
                    end
                end
                WRITE: begin
                    addr <= addr + 16'd1;
                    cnt  <= cnt - 16'd1;
                    wbuf <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_loader.sv
// Bench for param_loader: frames are described by (target, address, count,
// parameters); the expected write/done/err events follow from those fields
// directly. A single negedge process compares every output event in order.
module tb_param_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  wr_addr;
    logic [143:0] wr_data;
    logic         we_conv_w, we_conv_b, we_dense_w, we_dense_b;
    logic         busy, done, err;

    always #5 clk = ~clk;

    param_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .we_conv_w(we_conv_w), .we_conv_b(we_conv_b),
        .we_dense_w(we_dense_w), .we_dense_b(we_dense_b),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [3:0]   we;     // {conv_w, conv_b, dense_w, dense_b}
        logic [15:0]  addr;
        logic [143:0] data;
        logic         done;
        logic         err;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] bq[$];
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int depth_of(input logic [7:0] t);
        case (t)
            8'h01:   return 2576;
            8'h02:   return 112;
            8'h03:   return 33792;
            default: return 192;
        endcase
    endfunction

    function automatic logic [3:0] we_of(input logic [7:0] t);
        case (t)
            8'h01:   return 4'b1000;
            8'h02:   return 4'b0100;
            8'h03:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // Reference model: turn frame fields into the byte stream and the ordered
    // list of events the loader must produce for it.
    task automatic model_frame(input logic [7:0] t, input logic [15:0] a, input logic [15:0] c);
        int           p;
        logic [143:0] w;
        logic [15:0]  prm;
        logic [15:0]  ad;
        bq.delete();
        bq.push_back(t);
        if (t < 8'h01 || t > 8'h04) begin
            evq.push_back('{we:4'b0, addr:16'h0, data:144'h0, done:1'b0, err:1'b1});
            return;
        end
        bq.push_back(a[15:8]); bq.push_back(a[7:0]);
        bq.push_back(c[15:8]); bq.push_back(c[7:0]);
        if (int'(a) + int'(c) > depth_of(t)) begin
            evq.push_back('{we:4'b0, addr:16'h0, data:144'h0, done:1'b0, err:1'b1});
            return;
        end
        if (c == 16'd0) begin
            evq.push_back('{we:4'b0, addr:16'h0, data:144'h0, done:1'b1, err:1'b0});
            return;
        end
        p = (t == 8'h01) ? 9 : 1;
        for (int i = 0; i < int'(c); i++) begin
            w = '0;
            for (int k = 0; k < p; k++) begin
                prm = 16'($urandom);
                w[16*k +: 16] = prm;
                bq.push_back(prm[7:0]);
                bq.push_back(prm[15:8]);
            end
            ad = a + 16'(i);
            evq.push_back('{we:we_of(t), addr:ad, data:w, done:(i == int'(c) - 1), err:1'b0});
        end
    endtask

    // Drive every byte in bq with 0..gmax idle cycles before each.
    task automatic send_bytes(input int gmax);
        logic [7:0] b;
        logic       r, ok;
        while (bq.size() > 0) begin
            b = bq.pop_front();
            repeat ($urandom_range(gmax, 0)) begin
                in_data = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = b;
            ok = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk); r = in_ready;
                @(posedge clk);
                if (r) begin ok = 1'b1; break; end
            end
            #1;
            in_valid = 1'b0;
            if (!ok) begin
                n_chk++;
                $display("FAIL byte_accept_timeout: got no in_ready in 200 cycles, expected acceptance");
                bq.delete();
                return;
            end
        end
    endtask

    // Wait (bounded) for all expected events to be consumed by the checker.
    task automatic drain(input string name);
        for (int n = 0; n < 50 && evq.size() > 0; n++) @(posedge clk);
        #1;
        chk(name, 144'(evq.size()), 144'd0);
        evq.delete();
    endtask

    // Event checker: every cycle with a strobe or pulse must match the next
    // expected event exactly; writes must also see in_ready low.
    always @(negedge clk) begin
        logic [3:0] we;
        ev_t        e;
        if (!rst) begin
            we = {we_conv_w, we_conv_b, we_dense_w, we_dense_b};
            if (we != 4'b0 || done || err) begin
                n_chk++;
                if (evq.size() == 0) begin
                    $display("FAIL unexpected_event: got we=%b addr=%h done=%b err=%b, expected no event",
                             we, wr_addr, done, err);
                end else begin
                    e = evq.pop_front();
                    if (we === e.we && done === e.done && err === e.err &&
                        (we == 4'b0 || (wr_addr === e.addr && wr_data === e.data && in_ready === 1'b0)))
                        n_pass++;
                    else
                        $display("FAIL event: got we=%b addr=%h data=%h done=%b err=%b rdy=%b, expected we=%b addr=%h data=%h done=%b err=%b rdy=0",
                                 we, wr_addr, wr_data, done, err, in_ready,
                                 e.we, e.addr, e.data, e.done, e.err);
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 144'(in_ready), 144'd0);
        chk({tag, "_we"}, 144'({we_conv_w, we_conv_b, we_dense_w, we_dense_b}), 144'd0);
        chk({tag, "_flags"}, 144'({busy, done, err}), 144'd0);
        chk({tag, "_wr_addr"}, 144'(wr_addr), 144'd0);
        chk({tag, "_wr_data"}, wr_data, 144'd0);
    endtask

    initial begin
        logic [7:0]  t;
        int          c, a, d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 144'(in_ready), 144'd1);
        @(posedge clk); #1;

        // Two conv_b words, literal expectations
        bq = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        evq.push_back('{we:4'b0100, addr:16'd5, data:144'h1234, done:1'b0, err:1'b0});
        evq.push_back('{we:4'b0100, addr:16'd6, data:144'hABCD, done:1'b1, err:1'b0});
        send_bytes(0);
        chk("busy_in_last_write", 144'(busy), 144'd1);
        drain("conv_b_drain");
        chk("busy_after_frame", 144'(busy), 144'd0);

        // conv_w single word with parameters 1..9
        bq = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h01};
        for (int k = 1; k <= 9; k++) begin
            bq.push_back(8'(k));
            bq.push_back(8'h00);
        end
        evq.push_back('{we:4'b1000, addr:16'h0010,
                        data:144'h0009_0008_0007_0006_0005_0004_0003_0002_0001,
                        done:1'b1, err:1'b0});
        send_bytes(0);
        chk("ready_low_in_write", 144'(in_ready), 144'd0);
        drain("conv_w_drain");

        // dense_b range overflow by one, then the largest legal range
        bq = '{8'h04, 8'h00, 8'hBF, 8'h00, 8'h02};
        evq.push_back('{we:4'b0, addr:16'h0, data:144'h0, done:1'b0, err:1'b1});
        send_bytes(0);
        drain("dense_b_overflow");
        model_frame(8'h04, 16'd190, 16'd2);
        send_bytes(2);
        drain("dense_b_at_limit");

        // Bad target byte, then an empty frame
        bq = '{8'h07};
        evq.push_back('{we:4'b0, addr:16'h0, data:144'h0, done:1'b0, err:1'b1});
        send_bytes(0);
        drain("bad_tgt");
        chk("idle_after_bad_tgt", 144'({in_ready, busy}), 144'b10);
        bq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        evq.push_back('{we:4'b0, addr:16'h0, data:144'h0, done:1'b1, err:1'b0});
        send_bytes(0);
        drain("empty_frame");

        // dense_w at the top of memory, with and without gaps
        model_frame(8'h03, 16'd33790, 16'd2);
        send_bytes(0);
        drain("dense_w_top_nogap");
        model_frame(8'h03, 16'd33790, 16'd2);
        send_bytes(5);
        drain("dense_w_top_gaps");
        model_frame(8'h03, 16'd33791, 16'd2);
        send_bytes(3);
        drain("dense_w_past_top");

        // Reset after 7 payload bytes of a conv_w word
        bq = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h01};
        for (int k = 0; k < 7; k++) bq.push_back(8'($urandom));
        send_bytes(1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midframe_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midframe_ready_after", 144'({in_ready, busy}), 144'b10);
        @(posedge clk); #1;
        model_frame(8'h01, 16'h0020, 16'd1);
        send_bytes(1);
        drain("fresh_after_reset");

        // Randomized frames, many near the end of each memory
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(9, 0) == 0) begin
                t = ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 5));
                model_frame(t, 16'h0, 16'h0);
            end else begin
                t = 8'($urandom_range(4, 1));
                c = $urandom_range(3, 0);
                d = depth_of(t);
                if ($urandom_range(1, 0) == 0) a = d - c + $urandom_range(2, 0) - 1;
                else                           a = $urandom_range(d - 1, 0);
                model_frame(t, 16'(a), 16'(c));
            end
            send_bytes(3);
            drain("random_frame");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
